// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data memory block.
package dmem_pkg;
  localparam int DMEM_DEPTH = 16;
  typedef logic [3:0] word_t;
  typedef logic [3:0] addr_t;
  typedef enum logic [1:0] {IDLE, WRITE, HOLD} load_state_t;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchronizer with rising-edge detect for an asynchronous button.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise,
  output logic level
);
  logic s1_q, s2_q, prev_q;
  logic s1_d, s2_d, prev_d;
  always_comb begin
    s1_d = in;
    s2_d = s1_q;
    prev_d = s2_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      prev_q <= prev_d;
    end
  end
  assign rise = s2_q & ~prev_q;
  assign level = s2_q;
endmodule

// File: rtl/data_memory.sv
// data_memory: word memory with processor port, button-driven external load and optional display scanner (DMEM_SCAN_EN).
module data_memory import dmem_pkg::*; #(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int WIDTH = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] M_add,
  input  logic       M_we,
  input  logic       M_re,
  input  logic [3:0] M_wd,
  output logic [3:0] M_rd,
  input  logic [3:0] ext_add,
  input  logic [3:0] ext_wd,
  input  logic       ext_load,
  output logic       ext_done,
  output logic [3:0] scan_add,
  output logic [3:0] scan_data
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  load_state_t state_q, state_d;
  addr_t cap_add_q, cap_add_d;
  word_t cap_wd_q, cap_wd_d;
  logic ext_done_q, ext_done_d;
  logic rise, level;
  btn_edge u_btn (.clk(clk), .reset(reset), .in(ext_load), .rise(rise), .level(level));
  // Processor write wins; the captured external word waits in WRITE until the port is free.
  always_comb begin
    mem_d = mem_q;
    state_d = state_q;
    cap_add_d = cap_add_q;
    cap_wd_d = cap_wd_q;
    ext_done_d = 1'b0;
    if (M_we) mem_d[M_add] = M_wd;
    case (state_q)
      IDLE: if (rise) begin
        state_d = WRITE;
        cap_add_d = ext_add;
        cap_wd_d = ext_wd;
      end
      WRITE: if (!M_we) begin
        mem_d[cap_add_q] = cap_wd_q;
        ext_done_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: state_d = level ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      state_q <= IDLE;
      cap_add_q <= '0;
      cap_wd_q <= '0;
      ext_done_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      state_q <= state_d;
      cap_add_q <= cap_add_d;
      cap_wd_q <= cap_wd_d;
      ext_done_q <= ext_done_d;
    end
  end
  assign M_rd = M_re ? mem_q[M_add] : '0;
  assign ext_done = ext_done_q;
`ifdef DMEM_SCAN_EN
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  addr_t scan_q, scan_d;
  logic wrap;
  always_comb begin
    wrap = div_q == DW'(SCAN_DIV - 1);
    div_d = wrap ? '0 : div_q + 1'b1;
    scan_d = wrap ? scan_q + 1'b1 : scan_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      scan_q <= '0;
    end else begin
      div_q <= div_d;
      scan_q <= scan_d;
    end
  end
  assign scan_add = scan_q;
  assign scan_data = mem_q[scan_q];
`else
  logic unused_scan_div;
  assign unused_scan_div = ^SCAN_DIV;
  assign scan_add = 4'h0;
  assign scan_data = 4'h0;
`endif
endmodule
